// File: rtl/debounce_bank.sv
// Multi-channel input conditioner: two-flop synchroniser, stability-count debounce,
// registered rise/fall pulses and an optional auto-repeat press strobe per channel.
module debounce_bank #(
   parameter int unsigned         CHANNELS      = 8,
   parameter int unsigned         STABLE_CYCLES = 650000,
   parameter int unsigned         REPEAT_DELAY  = 32500000,
   parameter int unsigned         REPEAT_RATE   = 6500000,
   parameter logic [CHANNELS-1:0] INIT          = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] noisy,
   input  logic [CHANNELS-1:0] rpt_en,
   output logic [CHANNELS-1:0] clean,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] press
);

   localparam int unsigned CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DELAY = 2'd1;
   localparam logic [1:0] ST_RATE  = 2'd2;

   logic [CHANNELS-1:0] sync_a;
   logic [CHANNELS-1:0] sync_b;

   logic [CNT_W-1:0]    cnt_q   [CHANNELS];
   logic [CNT_W-1:0]    cnt_d   [CHANNELS];
   logic [RPT_W-1:0]    rcnt_q  [CHANNELS];
   logic [RPT_W-1:0]    rcnt_d  [CHANNELS];
   logic [1:0]          state_q [CHANNELS];
   logic [1:0]          state_d [CHANNELS];

   logic [CHANNELS-1:0] clean_d;
   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_d;
   logic [CHANNELS-1:0] press_d;
   logic [CHANNELS-1:0] rep_pulse;

   // Registers: synchroniser, counters, repeat FSM state and all outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_a <= INIT;
         sync_b <= INIT;
         clean  <= INIT;
         rise   <= '0;
         fall   <= '0;
         press  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]   <= '0;
            rcnt_q[i]  <= '0;
            state_q[i] <= ST_IDLE;
         end
      end else begin
         sync_a <= noisy;
         sync_b <= sync_a;
         clean  <= clean_d;
         rise   <= rise_d;
         fall   <= fall_d;
         press  <= press_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]   <= cnt_d[i];
            rcnt_q[i]  <= rcnt_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

   // Next-state: debounce counter, edge detection and repeat FSM per channel
   always_comb begin
      clean_d   = clean;
      rise_d    = '0;
      fall_d    = '0;
      rep_pulse = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]   = cnt_q[i];
         rcnt_d[i]  = rcnt_q[i];
         state_d[i] = state_q[i];
      end

      for (int i = 0; i < CHANNELS; i++) begin
         if (sync_b[i] == clean[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            clean_d[i] = sync_b[i];
            cnt_d[i]   = '0;
            rise_d[i]  = sync_b[i];
            fall_d[i]  = ~sync_b[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end

         // Leaving on release or disable wins over a count match in the same cycle
         case (state_q[i])
            ST_IDLE: begin
               rcnt_d[i] = '0;
               if (rise_d[i] && rpt_en[i]) begin
                  state_d[i] = ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (!clean[i] || !rpt_en[i]) begin
                  state_d[i] = ST_IDLE;
                  rcnt_d[i]  = '0;
               end else if (rcnt_q[i] == DELAY_LAST) begin
                  rep_pulse[i] = 1'b1;
                  rcnt_d[i]    = '0;
                  state_d[i]   = ST_RATE;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + RPT_W'(1);
               end
            end
            ST_RATE: begin
               if (!clean[i] || !rpt_en[i]) begin
                  state_d[i] = ST_IDLE;
                  rcnt_d[i]  = '0;
               end else if (rcnt_q[i] == RATE_LAST) begin
                  rep_pulse[i] = 1'b1;
                  rcnt_d[i]    = '0;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + RPT_W'(1);
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               rcnt_d[i]  = '0;
            end
         endcase
      end

      press_d = rise_d | rep_pulse;
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed timing checks plus randomized traffic
// compared every cycle against an event-level reference model.
module tb_debounce_bank;

   localparam int CH     = 4;
   localparam int STABLE = 4;
   localparam int DELAY  = 10;
   localparam int RATE   = 3;

   logic          clock;
   logic          reset;
   logic [CH-1:0] noisy;
   logic [CH-1:0] rpt_en;
   logic [CH-1:0] clean;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] press;

   int n_checks = 0;
   int n_fail   = 0;

   debounce_bank #(
      .CHANNELS      (CH),
      .STABLE_CYCLES (STABLE),
      .REPEAT_DELAY  (DELAY),
      .REPEAT_RATE   (RATE),
      .INIT          (4'h0)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .noisy  (noisy),
      .rpt_en (rpt_en),
      .clean  (clean),
      .rise   (rise),
      .fall   (fall),
      .press  (press)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Reference model: per channel, the debounced level flips once the synchronised
   // input has disagreed with it for STABLE consecutive edges; a held, enabled press
   // repeats at DELAY after the rise and every RATE edges after that.
   logic [CH-1:0] n1, n2;
   logic [CH-1:0] m_clean, m_rise, m_fall, m_press;
   int            run    [CH];
   bit            armed  [CH];
   int            anchor [CH];
   int            cyc = 0;
   bit            model_ok = 1'b0;

   initial begin
      forever begin
         @(negedge clock);
         if (model_ok) begin
            chk("clean", int'(clean), int'(m_clean));
            chk("rise",  int'(rise),  int'(m_rise));
            chk("fall",  int'(fall),  int'(m_fall));
            chk("press", int'(press), int'(m_press));
            chk("rise_and_fall", int'(rise & fall), 0);
         end
         // Inputs seen now are the ones the next posedge will sample
         cyc++;
         if (!reset) begin
            n1 = '0; n2 = '0;
            m_clean = '0; m_rise = '0; m_fall = '0; m_press = '0;
            for (int i = 0; i < CH; i++) begin
               run[i] = 0; armed[i] = 1'b0; anchor[i] = 0;
            end
         end else begin
            for (int i = 0; i < CH; i++) begin
               logic prev, r, f, rep;
               int   d;
               prev = m_clean[i]; r = 1'b0; f = 1'b0; rep = 1'b0;
               if (n2[i] != prev) begin
                  run[i]++;
                  if (run[i] == STABLE) begin
                     m_clean[i] = n2[i];
                     r = n2[i];
                     f = ~n2[i];
                     run[i] = 0;
                  end
               end else begin
                  run[i] = 0;
               end
               if (armed[i]) begin
                  if (!prev || !rpt_en[i]) begin
                     armed[i] = 1'b0;
                  end else begin
                     d = cyc - anchor[i];
                     if (d == DELAY || (d > DELAY && (d - DELAY) % RATE == 0)) rep = 1'b1;
                  end
               end
               if (r && rpt_en[i]) begin
                  armed[i]  = 1'b1;
                  anchor[i] = cyc;
               end
               m_rise[i]  = r;
               m_fall[i]  = f;
               m_press[i] = r | rep;
            end
            n2 = n1;
            n1 = noisy;
         end
         model_ok = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Edges from the next sample until clean[ch] reaches lvl; -1 if it never does
   task automatic lat_to(input int ch, input logic lvl, output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (clean[ch] == lvl) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic find_rise(input int ch, output bit found);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rise[ch]) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int bad;
      bit found;
      logic exp_p;

      reset = 1'b0; noisy = 4'hF; rpt_en = 4'h0;
      repeat (3) tick();
      chk("reset_clean", int'(clean), 0);
      chk("reset_pulses", int'({rise, fall, press}), 0);

      // Release with all inputs high: clean rises together on the 6th edge
      reset = 1'b1;
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (lat < 0 && clean == 4'hF) begin
            lat = k;
            chk("release_rise_all", int'(rise), 'hF);
         end
      end
      chk("release_latency", lat, 6);

      noisy = 4'h0;
      repeat (10) tick();

      // Single channel step up and back down
      noisy[0] = 1'b1;
      lat_to(0, 1'b1, lat);
      chk("ch0_rise_latency", lat, 6);
      chk("ch0_rise_pulse", int'(rise[0]), 1);
      tick();
      chk("ch0_rise_width", int'(rise[0]), 0);
      noisy[0] = 1'b0;
      lat_to(0, 1'b0, lat);
      chk("ch0_fall_latency", lat, 6);
      chk("ch0_fall_pulse", int'(fall[0]), 1);
      repeat (4) tick();

      // 3-high / 1-low glitch train never qualifies
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         noisy[1] = (c % 4 != 3);
         tick();
         if (clean[1] || rise[1] || fall[1]) bad++;
      end
      chk("ch1_glitch_rejected", bad, 0);
      noisy[1] = 1'b1;
      lat_to(1, 1'b1, lat);
      chk("ch1_after_glitch_latency", lat, 6);
      noisy[1] = 1'b0;
      repeat (10) tick();

      // Auto-repeat on channel 2
      rpt_en = 4'b0100;
      noisy[2] = 1'b1;
      find_rise(2, found);
      chk("ch2_rise_seen", int'(found), 1);
      chk("ch2_press_at_rise", int'(press[2]), 1);
      bad = 0;
      for (int off = 1; off <= 17; off++) begin
         tick();
         exp_p = (off == 10 || off == 13 || off == 16);
         if (press[2] != exp_p) bad++;
      end
      chk("ch2_repeat_pattern", bad, 0);
      noisy[2] = 1'b0;
      lat_to(2, 1'b0, lat);
      chk("ch2_release_latency", lat, 6);
      chk("ch2_fall_pulse", int'(fall[2]), 1);
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (press[2]) bad++;
      end
      chk("ch2_press_stops", bad, 0);

      // Disable repeat mid-RATE on channel 3, then re-enable while held
      rpt_en = 4'b1000;
      noisy[3] = 1'b1;
      find_rise(3, found);
      chk("ch3_rise_seen", int'(found), 1);
      repeat (12) tick();
      rpt_en[3] = 1'b0;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (press[3]) bad++;
      end
      chk("ch3_disable_stops_press", bad, 0);
      rpt_en[3] = 1'b1;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (press[3]) bad++;
      end
      chk("ch3_reenable_no_press", bad, 0);
      noisy[3] = 1'b0;
      lat_to(3, 1'b0, lat);
      noisy[3] = 1'b1;
      lat_to(3, 1'b1, lat);
      chk("ch3_new_rise_latency", lat, 6);
      chk("ch3_new_rise_press", int'(press[3]), 1);
      noisy = 4'h0; rpt_en = 4'h0;
      repeat (10) tick();

      // Randomized traffic: per-channel glitch density, sporadic enables and resets
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 2 + 4 * i) == 0) noisy[i] = ~noisy[i];
            if ($urandom_range(0, 60) == 0) rpt_en[i] = ~rpt_en[i];
         end
         reset = ($urandom_range(0, 599) != 0);
         tick();
      end
      reset = 1'b1;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Parametrised multi-channel input conditioner for switches and buttons on the 65 MHz domain. It replaces the per-signal debounce instances and the hand-written prev_* edge registers in the top level. For each channel it provides:
- synchronisation of the raw input
- a debounced level
- one-cycle rise and fall pulses
- an optional auto-repeat "press" strobe for held buttons, used for menu and cursor stepping

Parameters:
CHANNELS, 8, number of independent input channels (1..32)
STABLE_CYCLES, 650000, consecutive cycles a synchronised input must differ from clean before clean changes (10 ms at 65 MHz); legal range 2..2^24-1
REPEAT_DELAY, 32500000, cycles from the rise pulse to the first auto-repeat pulse (0.5 s); legal range 1..2^26-1
REPEAT_RATE, 6500000, cycles between subsequent auto-repeat pulses (0.1 s); legal range 1..2^26-1
INIT, 0, CHANNELS-bit reset value of the synchroniser flops and clean

Ports:
clock  input  1  system clock (clock_65mhz)
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock; 0 = reset asserted
noisy  input  CHANNELS  raw asynchronous inputs (buttons, switches)
rpt_en  input  CHANNELS  per-channel auto-repeat enable
clean  output  CHANNELS  debounced level
rise  output  CHANNELS  one-cycle pulse when clean goes 0->1
fall  output  CHANNELS  one-cycle pulse when clean goes 1->0
press  output  CHANNELS  one-cycle strobe: rise OR auto-repeat pulse

Behaviour:
- All state updates on posedge clock only. Channels are fully independent; there is no shared arbitration.
- Reset (reset==0 at an edge):
  - sync flops <= INIT; clean <= INIT
  - all counters <= 0; repeat FSM <= IDLE
  - rise, fall, press <= 0
  - No rise/fall pulse is generated on reset release, even where INIT differs from the input.
- Synchroniser: two flops per channel. A change on noisy before edge k is visible as s[i] after edge k+1.
- Stability counter cnt[i] (width ceil(log2(STABLE_CYCLES))):
  - If s[i]==clean[i]: cnt <= 0.
  - Else if cnt==STABLE_CYCLES-1: clean[i] <= s[i], cnt <= 0, and rise[i] or fall[i] is asserted for exactly that one cycle, coincident with the new clean value.
  - Else: cnt <= cnt+1.
- Latency: a clean step on noisy sampled at edge 1 changes clean at edge STABLE_CYCLES+2.
- Glitch handling: any return of s to clean before the count completes restarts the count from 0.
- Repeat FSM per channel, with states IDLE, DELAY, RATE and counter rcnt (width ceil(log2(max(REPEAT_DELAY, REPEAT_RATE)))):
  - IDLE: rcnt=0. On a rise pulse with rpt_en=1 -> DELAY, rcnt <= 0.
  - DELAY: rcnt++. When rcnt==REPEAT_DELAY-1: pulse press, rcnt <= 0, -> RATE.
  - RATE: rcnt++. When rcnt==REPEAT_RATE-1: pulse press, rcnt <= 0, stay in RATE.
  - From DELAY or RATE, if clean==0 or rpt_en==0: -> IDLE, rcnt <= 0, no press that cycle. This exit has priority over the count compare.
  - rpt_en rising while clean is already 1 does not start repeating; repeating starts only at the next rise.
- press = rise OR repeat pulse, registered. Timing: first repeat pulse REPEAT_DELAY cycles after the rise pulse, then every REPEAT_RATE cycles.
- With rpt_en=0, press equals rise exactly.
- Reset mid-count or mid-repeat: immediate return to reset state on that edge; no pulses in the reset cycle.
- Pulses never last more than one cycle. rise and fall are never both high on the same channel in the same cycle.

Test Plan:
Bench parameters: CHANNELS=4, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, INIT=0.
1. Hold reset=0 for 3 cycles with noisy=4'hF, then release -> clean=0 and no pulses during reset. After release, clean[3:0] becomes 4'hF exactly 6 edges after noisy is first sampled, with rise=4'hF for one cycle.
2. noisy[0] step 0->1 at edge 1 -> clean[0]=1 and rise[0]=1 at edge 6 only. Stepping back 1->0 gives fall[0]=1 exactly 6 edges later.
3. noisy[1] toggles with 3-cycle high / 1-cycle low glitches for 40 cycles -> clean[1] stays 0, no rise/fall. A following stable high gives clean[1]=1 at edge 6 after the last transition.
4. rpt_en[2]=1, noisy[2] held high -> press[2] at the rise cycle T, then at T+10, T+13, T+16. Release noisy -> press stops; fall[2] is asserted 6 edges after release.
5. rpt_en[3] dropped to 0 during RATE -> no press from that edge on. Re-raising rpt_en while clean[3]=1 yields no press until a new rise.
6. All four channels switched simultaneously with differing glitch patterns -> each channel's clean/rise/fall timing matches its independent reference model; no cross-channel interaction.
